mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 74 +++++++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared definitions for the memory port arbiter: FSM state encoding, the
// served-port (SRC) encoding, access size codes and the captured bus command
// record. Helper functions build the bus command for each port so the top
// level only has to choose between them.
// ----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    // Which port owns the transaction currently on the bus.
    typedef enum logic {
        SRC_FETCH = 1'b0,
        SRC_DATA  = 1'b1
    } arb_src_t;

    // Access size codes, shared between core and bus.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    // Width of the WAIT-state timeout counter.
    localparam int TIMEOUT_W = 8;

    // Everything that is driven onto the bus for one transaction. Captured
    // once when leaving IDLE and held until the transaction completes.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    // Instruction fetches are always unsigned-agnostic full-word reads.
    function automatic bus_cmd_t fetch_cmd(input logic [31:0] addr);
        bus_cmd_t cmd;
        cmd.we    = 1'b0;
        cmd.size  = SIZE_WORD;
        cmd.uns   = 1'b0;
        cmd.addr  = addr;
        cmd.wdata = 32'h0;
        return cmd;
    endfunction

    // A data access with both read and write raised is a write: the store
    // wins so a confused core never silently drops store data.
    function automatic bus_cmd_t data_cmd(
        input logic        write,
        input logic [1:0]  size,
        input logic        uns,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        bus_cmd_t cmd;
        cmd.we    = write;
        cmd.size  = size;
        cmd.uns   = uns;
        cmd.addr  = addr;
        cmd.wdata = write ? wdata : 32'h0;
        return cmd;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported bus between the instruction fetch port and the
// data (load/store) port. Exactly one transaction is outstanding at a time.
// Data requests have fixed priority over fetch; a transaction that has left
// IDLE is never preempted. A WAIT-state timeout aborts a transaction whose
// response never arrives and raises a sticky bus_error.
//
// Ports
//   clk, reset              clock; synchronous active-low reset
//   fetch_address           fetch address (the fetch port always requests)
//   fetch_data, fetch_stall registered instruction word / not-yet-served
//   memory_read/_write      data port load/store request
//   memory_size             0=byte, 1=half, 2=word
//   load_store_unsigned     zero-extend loads
//   memory_address/_write_data  data address / store data
//   memory_read_data        registered load data
//   mem_stall               data access not yet served
//   bus_req .. bus_wdata    shared bus command, stable from REQ until DONE
//   bus_gnt                 bus accepted the request this cycle
//   bus_rvalid, bus_rdata   response (or write ack) and its data
//   bus_error               sticky timeout flag
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_data,
    output logic        fetch_stall,

    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [1:0]  memory_size,
    input  logic        load_store_unsigned,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_data,
    output logic [31:0] memory_read_data,
    output logic        mem_stall,

    output logic        bus_req,
    output logic        bus_we,
    output logic [1:0]  bus_size,
    output logic        bus_unsigned,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_error
);

    // One wider than the counter so the limit compare cannot wrap.
    localparam logic [TIMEOUT_W:0] TIMEOUT_LIMIT = (TIMEOUT_W + 1)'(TIMEOUT_CYCLES);

    arb_state_t           state;
    arb_src_t             src;
    logic [TIMEOUT_W-1:0] timeout_count;
    bus_cmd_t             cmd_q;
    bus_cmd_t             next_cmd;
    logic                 data_request;
    logic                 timeout_hit;

    assign data_request = memory_read | memory_write;

    // The counter holds the number of WAIT cycles already spent without a
    // response; this cycle is the last one allowed when count+1 hits the limit.
    assign timeout_hit = ({1'b0, timeout_count} + 1'b1) >= TIMEOUT_LIMIT;

    // Command that would be captured if IDLE is left this cycle.
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_cmd = fetch_cmd(fetch_address);
        if (data_request) begin
            next_cmd = data_cmd(memory_write, memory_size, load_store_unsigned,
                                memory_address, memory_write_data);
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the values from before the edge, independent of the
    // order the statements are written in.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= ST_IDLE;
            src              <= SRC_FETCH;
            timeout_count    <= '0;
            bus_req          <= 1'b0;
            cmd_q            <= '0;
            fetch_data       <= 32'h0;
            memory_read_data <= 32'h0;
            bus_error        <= 1'b0;
        end else begin
            case (state)
                // The fetch port always requests, so IDLE lasts one cycle;
                // the only decision is which port wins.
                ST_IDLE: begin
                    state   <= ST_REQ;
                    bus_req <= 1'b1;
                    cmd_q   <= next_cmd;
                    src     <= data_request ? SRC_DATA : SRC_FETCH;
                end

                // Hold the request until accepted. rvalid is ignored here.
                ST_REQ: begin
                    if (bus_gnt) begin
                        state         <= ST_WAIT;
                        bus_req       <= 1'b0;
                        timeout_count <= '0;
                    end
                end

                // Response or write ack ends the transaction; otherwise count
                // towards the timeout. gnt is ignored here.
                ST_WAIT: begin
                    if (bus_rvalid) begin
                        state <= ST_DONE;
                        if (src == SRC_FETCH) begin
                            fetch_data <= bus_rdata;
                        end else if (!cmd_q.we) begin
                            memory_read_data <= bus_rdata;
                        end
                    end else if (timeout_hit) begin
                        // Abort: the served port is released with its data
                        // register untouched and the error is latched.
                        state     <= ST_DONE;
                        bus_error <= 1'b1;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end

                // Single release cycle for the served port.
                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A port's stall drops only in the DONE cycle of its own transaction.
    // mem_stall is additionally qualified by a live data request so an idle
    // data port never reports a stall.
    assign fetch_stall = !((state == ST_DONE) && (src == SRC_FETCH));
    assign mem_stall   = data_request && !((state == ST_DONE) && (src == SRC_DATA));

    assign bus_we       = cmd_q.we;
    assign bus_size     = cmd_q.size;
    assign bus_unsigned = cmd_q.uns;
    assign bus_addr     = cmd_q.addr;
    assign bus_wdata    = cmd_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A bus responder process answers
// requests with configurable grant/response delays. A transaction-level
// reference model tracks the outstanding transaction and the outputs it
// implies; a compare process checks the DUT against it every cycle, and the
// directed scenarios add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fetch_address = 32'h0;
    logic [31:0] fetch_data;
    logic        fetch_stall;
    logic        memory_read = 1'b0;
    logic        memory_write = 1'b0;
    logic [1:0]  memory_size = 2'd0;
    logic        load_store_unsigned = 1'b0;
    logic [31:0] memory_address = 32'h0;
    logic [31:0] memory_write_data = 32'h0;
    logic [31:0] memory_read_data;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_size;
    logic        bus_unsigned;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_error;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic cmp_on = 1'b0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk                (clk),
        .reset              (reset),
        .fetch_address      (fetch_address),
        .fetch_data         (fetch_data),
        .fetch_stall        (fetch_stall),
        .memory_read        (memory_read),
        .memory_write       (memory_write),
        .memory_size        (memory_size),
        .load_store_unsigned(load_store_unsigned),
        .memory_address     (memory_address),
        .memory_write_data  (memory_write_data),
        .memory_read_data   (memory_read_data),
        .mem_stall          (mem_stall),
        .bus_req            (bus_req),
        .bus_we             (bus_we),
        .bus_size           (bus_size),
        .bus_unsigned       (bus_unsigned),
        .bus_addr           (bus_addr),
        .bus_wdata          (bus_wdata),
        .bus_gnt            (bus_gnt),
        .bus_rvalid         (bus_rvalid),
        .bus_rdata          (bus_rdata),
        .bus_error          (bus_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Memory contents seen by the responder: address 0 holds a NOP, every
    // other address returns a recognisable pattern derived from it.
    function automatic logic [31:0] resp_fn(input logic [31:0] addr);
        return (addr == 32'h0) ? 32'h0000_0013 : (addr ^ 32'h5A5A_0000);
    endfunction

    // ------------------------------------------------------------------
    // Bus responder
    // ------------------------------------------------------------------
    int gnt_delay   = 0;   // extra REQ cycles before gnt
    int rvalid_delay = 0;  // extra WAIT cycles before rvalid
    logic no_response = 1'b0;
    int stray_req = 0;     // bump to inject one unsolicited rvalid
    int stray_ack = 0;
    int req_age = 0;
    int wait_age = -1;

    always begin
        @(posedge clk);
        #1;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        if (stray_ack != stray_req) begin
            stray_ack  = stray_req;
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hBAD0_BAD0;
        end else if (!reset) begin
            req_age  = 0;
            wait_age = -1;
        end else if (bus_req) begin
            wait_age = -1;
            if (req_age >= gnt_delay) begin
                bus_gnt  = 1'b1;
                req_age  = 0;
                wait_age = 0;
            end else begin
                req_age++;
            end
        end else if (wait_age >= 0) begin
            if (!no_response && wait_age >= rvalid_delay) begin
                bus_rvalid = 1'b1;
                bus_rdata  = resp_fn(bus_addr);
                wait_age   = -1;
            end else begin
                wait_age++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: one outstanding transaction record plus the
    // registered results the core can see.
    // ------------------------------------------------------------------
    logic        m_active = 1'b0;  // a transaction has been issued
    logic        m_granted = 1'b0; // ... and accepted by the bus
    logic        m_done = 1'b0;    // this cycle releases the served port
    logic        m_data = 1'b0;    // served port is the data port
    logic        m_we = 1'b0;
    logic [1:0]  m_size = 2'd0;
    logic        m_uns = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_load = 32'h0;
    logic        m_err = 1'b0;
    int          m_wait = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_active <= 1'b0; m_granted <= 1'b0; m_done <= 1'b0; m_data <= 1'b0;
            m_we <= 1'b0; m_size <= 2'd0; m_uns <= 1'b0; m_addr <= 32'h0; m_wdata <= 32'h0;
            m_fetch <= 32'h0; m_load <= 32'h0; m_err <= 1'b0; m_wait <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_active) begin
            m_active  <= 1'b1;
            m_granted <= 1'b0;
            if (memory_read || memory_write) begin
                m_data  <= 1'b1;
                m_we    <= memory_write;
                m_size  <= memory_size;
                m_uns   <= load_store_unsigned;
                m_addr  <= memory_address;
                m_wdata <= memory_write ? memory_write_data : 32'h0;
            end else begin
                m_data  <= 1'b0;
                m_we    <= 1'b0;
                m_size  <= 2'd2;
                m_uns   <= 1'b0;
                m_addr  <= fetch_address;
                m_wdata <= 32'h0;
            end
        end else if (!m_granted) begin
            if (bus_gnt) begin
                m_granted <= 1'b1;
                m_wait    <= 0;
            end
        end else if (bus_rvalid) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
            if (!m_data) m_fetch <= bus_rdata;
            else if (!m_we) m_load <= bus_rdata;
        end else if (m_wait + 1 >= TIMEOUT) begin
            m_err    <= 1'b1;
            m_active <= 1'b0;
            m_done   <= 1'b1;
        end else begin
            m_wait <= m_wait + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cmp_bus_req", bus_req, m_active && !m_granted);
            check("cmp_fetch_stall", fetch_stall, !(m_done && !m_data));
            check("cmp_mem_stall", mem_stall, (memory_read || memory_write) && !(m_done && m_data));
            check("cmp_bus_error", bus_error, m_err);
            check("cmp_fetch_data", fetch_data, m_fetch);
            check("cmp_load_data", memory_read_data, m_load);
            if (m_active) begin
                check("cmp_bus_addr", bus_addr, m_addr);
                check("cmp_bus_wdata", bus_wdata, m_wdata);
                check("cmp_bus_we", bus_we, m_we);
                check("cmp_bus_size", bus_size, m_size);
                check("cmp_bus_unsigned", bus_unsigned, m_uns);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check_reset_values(input string name);
        check({name, "_bus_req"}, bus_req, 1'b0);
        check({name, "_bus_we"}, bus_we, 1'b0);
        check({name, "_bus_addr"}, bus_addr, 32'h0);
        check({name, "_bus_wdata"}, bus_wdata, 32'h0);
        check({name, "_bus_size"}, bus_size, 2'd0);
        check({name, "_bus_unsigned"}, bus_unsigned, 1'b0);
        check({name, "_fetch_data"}, fetch_data, 32'h0);
        check({name, "_load_data"}, memory_read_data, 32'h0);
        check({name, "_bus_error"}, bus_error, 1'b0);
        check({name, "_fetch_stall"}, fetch_stall, 1'b1);
    endtask

    task automatic wait_for_gnt(input string name);
        logic found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus_req && bus_gnt) found = 1'b1;
        end
        check({name, "_gnt_seen"}, found, 1'b1);
    endtask

    task automatic wait_fetch_done(input string name, output int at);
        logic found = 1'b0;
        at = -1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (!fetch_stall) begin found = 1'b1; at = cyc; end
        end
        check({name, "_fetch_done_seen"}, found, 1'b1);
    endtask

    task automatic wait_mem_done(input string name, output int at);
        logic found = 1'b0;
        at = -1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if ((memory_read || memory_write) && !mem_stall) begin found = 1'b1; at = cyc; end
        end
        check({name, "_mem_done_seen"}, found, 1'b1);
    endtask

    // Issue one data access, check the captured command when it reaches
    // the bus, and release the request after the port is served.
    task automatic do_data(input string name, input logic rd, input logic wr,
                           input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_we);
        logic found = 1'b0;
        int t;
        @(posedge clk); #1;
        memory_read = rd; memory_write = wr; memory_size = size;
        load_store_unsigned = uns; memory_address = addr; memory_write_data = wdata;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus_req && bus_addr == addr) found = 1'b1;
        end
        check({name, "_seen"}, found, 1'b1);
        check({name, "_we"}, bus_we, exp_we);
        check({name, "_size"}, bus_size, size);
        check({name, "_unsigned"}, bus_unsigned, uns);
        wait_mem_done(name, t);
        if (!exp_we) check({name, "_load_data"}, memory_read_data, resp_fn(addr));
        @(posedge clk); #1;
        memory_read = 1'b0; memory_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int t_mem;
        int t_fetch;
        int n;
        logic found;

        // Reset state.
        @(posedge clk); #1;
        cmp_on = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_values("rst0");

        // Fetch only: immediate gnt, rvalid next cycle, NOP returned.
        @(posedge clk); #1;
        reset = 1'b1;
        lat = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!fetch_stall) found = 1'b1;
            else lat++;
        end
        check("fetch_latency", lat, 3);
        check("fetch_nop_data", fetch_data, 32'h0000_0013);
        @(negedge clk);
        check("fetch_stall_one_cycle", fetch_stall, 1'b1);

        // Load and fetch arrive in the same IDLE cycle: data first.
        @(posedge clk); #1;
        reset = 1'b0;
        fetch_address = 32'h40;
        memory_read = 1'b1; memory_write = 1'b0; memory_size = 2'd2;
        memory_address = 32'h100;
        @(posedge clk); #1;
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus_req) found = 1'b1;
        end
        check("prio_first_req_seen", found, 1'b1);
        check("prio_first_addr", bus_addr, 32'h100);
        check("prio_first_we", bus_we, 1'b0);
        wait_mem_done("prio", t_mem);
        check("prio_load_data", memory_read_data, 32'h5A5A_0100);
        @(posedge clk); #1;
        memory_read = 1'b0;
        wait_fetch_done("prio", t_fetch);
        check("prio_mem_before_fetch", t_mem < t_fetch, 1'b1);
        check("prio_fetch_data", fetch_data, 32'h5A5A_0040);

        // Store word with a delayed grant; core inputs change while stalled.
        gnt_delay = 3;
        @(posedge clk); #1;
        memory_write = 1'b1; memory_size = 2'd2;
        memory_address = 32'h200; memory_write_data = 32'hDEAD_BEEF;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus_req && bus_we) found = 1'b1;
        end
        check("store_req_seen", found, 1'b1);
        check("store_addr", bus_addr, 32'h200);
        check("store_wdata", bus_wdata, 32'hDEAD_BEEF);
        check("store_size", bus_size, 2'd2);
        n = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            memory_address = 32'h300; memory_write_data = 32'h0;
            @(negedge clk);
            if (bus_req) n++;
            else found = 1'b1;
        end
        check("store_req_cycles", n, 4);
        check("store_we_held", bus_we, 1'b1);
        check("store_addr_held", bus_addr, 32'h200);
        check("store_wdata_held", bus_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("store_mem_stall_low", mem_stall, 1'b0);
        @(posedge clk); #1;
        memory_write = 1'b0;

        // Read+write together is a write; unsigned byte load.
        gnt_delay = 1;
        rvalid_delay = 2;
        do_data("rdwr", 1'b1, 1'b1, 2'd2, 1'b0, 32'h300, 32'h1234_5678, 1'b1);
        do_data("ldbu", 1'b1, 1'b0, 2'd0, 1'b1, 32'h104, 32'h0, 1'b0);
        do_data("ldh", 1'b1, 1'b0, 2'd1, 1'b0, 32'h108, 32'h0, 1'b0);

        // Timeout: grant but never respond.
        gnt_delay = 0;
        rvalid_delay = 0;
        wait_fetch_done("pre_to", t_fetch);
        @(posedge clk); #1;
        no_response = 1'b1;
        wait_for_gnt("to");
        check("to_error_before", bus_error, 1'b0);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (!fetch_stall) found = 1'b1;
            else n++;
        end
        check("to_wait_cycles", n, TIMEOUT);
        check("to_error_set", bus_error, 1'b1);
        check("to_fetch_data_kept", fetch_data, 32'h5A5A_0040);
        @(negedge clk);
        check("to_back_idle_req", bus_req, 1'b0);
        check("to_back_idle_stall", fetch_stall, 1'b1);
        @(posedge clk); #1;
        no_response = 1'b0;
        repeat (30) @(negedge clk);
        check("to_error_sticky", bus_error, 1'b1);

        // Reset during WAIT, then a stray rvalid, then a normal fetch.
        rvalid_delay = 5;
        wait_for_gnt("rw");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_values("rst1");
        @(posedge clk); #1;
        reset = 1'b1;
        fetch_address = 32'h80;
        stray_req++;
        repeat (3) begin
            @(negedge clk);
            check("rw_stray_ignored", fetch_data, 32'h0);
        end
        wait_fetch_done("rw", t_fetch);
        check("rw_fetch_data", fetch_data, 32'h5A5A_0080);
        check("rw_error_clear", bus_error, 1'b0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
